// File: rtl/core_pkg.sv
// Constants and types shared between the instruction-memory loader and the core.
package core_pkg;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned IW    = 14;

   localparam logic [IW-1:0] NOP_INSTR = 14'b0;

   typedef enum logic [1:0] {
      IDLE,
      GET_LO,
      GET_HI,
      DONE
   } ldr_state_t;
endpackage

// File: rtl/imem_store.sv
// DEPTH x IW instruction store: synchronous write, asynchronous read, no reset.
module imem_store #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned IW    = 14
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   logic [IW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Byte-serial program loader in front of the core's combinational fetch port;
// holds the core idle (core_run=0) until a load completes.
module imem_loader #(
   parameter int unsigned DEPTH = core_pkg::DEPTH,
   parameter int unsigned AW    = core_pkg::AW,
   parameter int unsigned IW    = core_pkg::IW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_start,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [7:0]    ld_data,
   input  logic          ld_last,
   input  logic [AW-1:0] pc,
   output logic [IW-1:0] instraction,
   output logic          core_run,
   output logic          ld_err,
   output logic [AW:0]   words_loaded
);

   import core_pkg::*;

   // High-byte bits that fall outside the instruction width.
   localparam logic [7:0] HI_MASK = 8'(8'hFF << (IW - 8));

   ldr_state_t    state, state_nxt;
   logic [AW-1:0] wptr;
   logic [7:0]    lo_byte;
   logic [IW-1:0] wdata;
   logic [IW-1:0] rdata;
   logic          do_start, lo_we, we, finish;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // ld_start outranks any simultaneous transfer, so an aborted byte is dropped.
   always_comb begin
      state_nxt = state;
      ld_ready  = 1'b0;
      do_start  = 1'b0;
      lo_we     = 1'b0;
      we        = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (ld_start) begin
               do_start  = 1'b1;
               state_nxt = GET_LO;
            end
         end
         GET_LO: begin
            ld_ready = 1'b1;
            if (ld_start) begin
               do_start  = 1'b1;
               state_nxt = GET_LO;
            end else if (ld_valid) begin
               lo_we     = 1'b1;
               state_nxt = GET_HI;
            end
         end
         GET_HI: begin
            ld_ready = 1'b1;
            if (ld_start) begin
               do_start  = 1'b1;
               state_nxt = GET_LO;
            end else if (ld_valid) begin
               we = 1'b1;
               if (ld_last || wptr == AW'(DEPTH - 1)) begin
                  finish    = 1'b1;
                  state_nxt = DONE;
               end else begin
                  state_nxt = GET_LO;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr         <= '0;
         words_loaded <= '0;
         core_run     <= 1'b0;
         ld_err       <= 1'b0;
         lo_byte      <= '0;
      end else if (do_start) begin
         wptr         <= '0;
         words_loaded <= '0;
         core_run     <= 1'b0;
         ld_err       <= 1'b0;
      end else begin
         if (lo_we) lo_byte <= ld_data;
         if (we) begin
            words_loaded <= words_loaded + (AW + 1)'(1);
            if ((ld_data & HI_MASK) != '0) ld_err <= 1'b1;
            if (finish) core_run <= 1'b1;
            else        wptr     <= wptr + AW'(1);
         end
      end
   end

   assign wdata = IW'({ld_data & ~HI_MASK, lo_byte});

   imem_store #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .IW    (IW)
   ) u_store (
      .clk   (clk),
      .we    (we),
      .waddr (wptr),
      .wdata (wdata),
      .raddr (pc),
      .rdata (rdata)
   );

   assign instraction = (core_run && ({1'b0, pc} < words_loaded)) ? rdata : IW'(NOP_INSTR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_start;
   logic        ld_valid;
   logic        ld_ready;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic [4:0]  pc;
   logic [13:0] instraction;
   logic        core_run;
   logic        ld_err;
   logic [5:0]  words_loaded;

   int n_checks = 0;
   int n_fail   = 0;

   imem_loader #(
      .DEPTH (32),
      .AW    (5),
      .IW    (14)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ld_start     (ld_start),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_data      (ld_data),
      .ld_last      (ld_last),
      .pc           (pc),
      .instraction  (instraction),
      .core_run     (core_run),
      .ld_err       (ld_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_load();
      @(negedge clk);
      ld_start = 1'b1;
      @(posedge clk);
      #1;
      ld_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      int n = 0;
      @(negedge clk);
      while (!ld_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ld_ready) check("ready_timeout", {31'b0, ld_ready}, 32'd1);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic pulse_valid(input logic [7:0] d);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = d;
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
   endtask

   task automatic send_word(input logic [13:0] w, input logic last);
      send_byte(w[7:0], 1'b0);
      send_byte({2'b00, w[13:8]}, last);
   endtask

   task automatic fetch(input string tag, input logic [4:0] a, input logic [13:0] exp);
      pc = a;
      #1;
      check(tag, {18'b0, instraction}, {18'b0, exp});
   endtask

   function automatic logic [13:0] pattern(input int i);
      logic [15:0] v;
      v = 16'(i * 16'h0123 + 16'h0055);
      return v[13:0];
   endfunction

   initial begin
      rst      = 1'b0;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_data  = '0;
      ld_last  = 1'b0;
      pc       = '0;
      #12;
      check("rst_ready", {31'b0, ld_ready}, 0);
      check("rst_core_run", {31'b0, core_run}, 0);
      check("rst_err", {31'b0, ld_err}, 0);
      check("rst_words", {26'b0, words_loaded}, 0);
      check("rst_instr", {18'b0, instraction}, 0);
      @(negedge clk);
      rst = 1'b1;

      // Bytes offered while idle are ignored.
      pulse_valid(8'hAA);
      pulse_valid(8'h01);
      check("idle_words", {26'b0, words_loaded}, 0);
      check("idle_ready", {31'b0, ld_ready}, 0);

      // Three-word load.
      start_load();
      check("t1_ready", {31'b0, ld_ready}, 1);
      send_word(14'h1A5B, 1'b0);
      send_word(14'h0001, 1'b0);
      send_byte(8'hFF, 1'b0);
      check("t1_run_before_last", {31'b0, core_run}, 0);
      send_byte(8'h3F, 1'b1);
      check("t1_core_run", {31'b0, core_run}, 1);
      check("t1_words", {26'b0, words_loaded}, 3);
      check("t1_err", {31'b0, ld_err}, 0);
      check("t1_ready_done", {31'b0, ld_ready}, 0);
      fetch("t1_pc0", 5'd0, 14'h1A5B);
      fetch("t1_pc1", 5'd1, 14'h0001);
      fetch("t1_pc2", 5'd2, 14'h3FFF);
      fetch("t1_pc3", 5'd3, 14'h0000);

      // Full-depth load without ld_last.
      start_load();
      check("t2_run_cleared", {31'b0, core_run}, 0);
      for (int i = 0; i < 31; i++) send_word(pattern(i), 1'b0);
      check("t2_words31", {26'b0, words_loaded}, 31);
      check("t2_run31", {31'b0, core_run}, 0);
      fetch("t2_fetch_loading", 5'd0, 14'h0000);
      send_word(pattern(31), 1'b0);
      check("t2_core_run", {31'b0, core_run}, 1);
      check("t2_words32", {26'b0, words_loaded}, 32);
      check("t2_ready_after", {31'b0, ld_ready}, 0);
      pulse_valid(8'h5A);
      check("t2_words_65th", {26'b0, words_loaded}, 32);
      fetch("t2_pc0", 5'd0, pattern(0));
      fetch("t2_pc17", 5'd17, pattern(17));
      fetch("t2_pc31", 5'd31, pattern(31));

      // Format error: high byte carries bits beyond IW.
      start_load();
      send_byte(8'h10, 1'b0);
      send_byte(8'hC5, 1'b1);
      check("t3_err", {31'b0, ld_err}, 1);
      check("t3_core_run", {31'b0, core_run}, 1);
      fetch("t3_pc0", 5'd0, 14'h0510);
      start_load();
      check("t3_err_cleared", {31'b0, ld_err}, 0);

      // Abort with ld_start colliding with a high-byte transfer.
      send_word(14'h0AAA, 1'b0);
      send_word(14'h1555, 1'b0);
      send_byte(8'h77, 1'b0);
      check("t4_words2", {26'b0, words_loaded}, 2);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = 8'h01;
      ld_start = 1'b1;
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
      ld_start = 1'b0;
      check("t4_words0", {26'b0, words_loaded}, 0);
      check("t4_core_run", {31'b0, core_run}, 0);
      check("t4_ready", {31'b0, ld_ready}, 1);
      send_word(14'h2222, 1'b1);
      check("t4_words1", {26'b0, words_loaded}, 1);
      fetch("t4_pc0", 5'd0, 14'h2222);
      fetch("t4_pc1", 5'd1, 14'h0000);

      // Asynchronous reset in the middle of a high byte.
      start_load();
      send_word(14'h0123, 1'b0);
      send_byte(8'h45, 1'b0);
      check("t5_words_pre", {26'b0, words_loaded}, 1);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = 8'h07;
      #2;
      rst = 1'b0;
      #1;
      check("t5_ready_async", {31'b0, ld_ready}, 0);
      check("t5_run_async", {31'b0, core_run}, 0);
      check("t5_words_async", {26'b0, words_loaded}, 0);
      fetch("t5_instr", 5'd0, 14'h0000);
      ld_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      pulse_valid(8'h11);
      pulse_valid(8'h22);
      pulse_valid(8'h33);
      check("t5_words_ignored", {26'b0, words_loaded}, 0);
      check("t5_ready_idle", {31'b0, ld_ready}, 0);
      start_load();
      send_word(14'h0ABC, 1'b1);
      fetch("t5_reload_pc0", 5'd0, 14'h0ABC);

      // Stall with ld_valid low in the middle of a word.
      start_load();
      send_byte(8'h34, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check("t6_ready_hold", {31'b0, ld_ready}, 1);
      check("t6_words_hold", {26'b0, words_loaded}, 0);
      send_byte(8'h12, 1'b1);
      check("t6_words", {26'b0, words_loaded}, 1);
      check("t6_core_run", {31'b0, core_run}, 1);
      fetch("t6_pc0", 5'd0, 14'h1234);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
